// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions for the fetch stage: architectural constants and the
// {pc, inst} packet carried from instruction memory towards decode.
package fetch_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    localparam int FETCH_FIFO_DEPTH = 2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_pkt_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's instruction-memory and decode-side handshakes.
// master is the fetch stage itself; slave is the memory/decode environment.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_inst;

    modport master (
        input  redirect, redirect_pc,
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output id_valid, id_pc, id_inst,
        input  id_ready
    );

    modport slave (
        output redirect, redirect_pc,
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  id_valid, id_pc, id_inst,
        output id_ready
    );

endinterface

// File: rtl/fetch_stage_fifo.sv
// Two-entry in-order FIFO with a shifting head slot; used both for the fetched
// instruction buffer and for the PC tags of granted-but-unanswered requests.
module fetch_fifo
    import fetch_stage_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] entry0_q, entry0_d;
    logic [WIDTH-1:0] entry1_q, entry1_d;
    logic [1:0]       count_q, count_d;
    logic [1:0]       level;

    // The pop is applied first so that a push into a full FIFO in the same
    // cycle lands in the slot the pop just vacated.
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        level    = count_q;

        if (pop_i && level != 2'd0) begin
            entry0_d = entry1_q;
            level    = level - 2'd1;
        end

        if (push_i && level != 2'(FETCH_FIFO_DEPTH)) begin
            if (level == 2'd0) begin
                entry0_d = data_i;
            end else begin
                entry1_d = data_i;
            end
            level = level + 2'd1;
        end

        count_d = flush_i ? 2'd0 : level;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = entry0_q;
    assign count_o = count_q;

    property p_no_overflow;
        @(posedge clk_i) disable iff (rst_i)
            (push_i && !flush_i && count_q == 2'(FETCH_FIFO_DEPTH)) |-> pop_i;
    endproperty
    a_no_overflow: assert property (p_no_overflow);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues word fetches, pairs in-order responses with
// their PCs, buffers up to two instructions for decode, and handles redirects.
module fetch_stage
    import fetch_stage_pkg::XLEN, fetch_stage_pkg::fetch_pkt_t, fetch_stage_pkg::word_align;
#(
    parameter logic [31:0] RESET_PC = fetch_stage_pkg::RESET_PC,
    parameter logic [31:0] NOP_INST = fetch_stage_pkg::NOP_INST
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,

    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,

    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [XLEN-1:0] id_pc_o,
    output logic [XLEN-1:0] id_inst_o
);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]      outstanding_q, outstanding_d;
    logic [1:0]      discard_q, discard_d;

    logic            grant;
    logic            rsp_valid;
    logic            rsp_push;
    logic            id_pop;

    logic [XLEN-1:0] tag_head;
    logic [1:0]      tag_count;

    fetch_pkt_t      rsp_pkt;
    fetch_pkt_t      buf_head;
    logic [1:0]      buf_count;

    // A response only counts if a tag is waiting for it; the memory never
    // answers otherwise, so this just keeps the tag FIFO from underflowing.
    assign rsp_valid = imem_rvalid_i && (tag_count != 2'd0);
    assign grant     = imem_req_o && imem_gnt_i;
    assign rsp_push  = rsp_valid && !redirect_i && (discard_q == 2'd0);
    assign id_pop    = id_valid_o && id_ready_i;

    // Credits: every granted request must have a guaranteed buffer slot.
    // A pop in the current cycle frees its slot only from the next cycle on.
    assign imem_req_o  = !rst_i &&
                         (({1'b0, outstanding_q} + {1'b0, buf_count}) < 3'd2);
    assign imem_addr_o = fetch_pc_q;

    assign rsp_pkt.pc   = tag_head;
    assign rsp_pkt.inst = imem_rdata_i;

    fetch_fifo #(
        .WIDTH (XLEN)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (1'b0),
        .push_i  (grant),
        .data_i  (fetch_pc_q),
        .pop_i   (rsp_valid),
        .head_o  (tag_head),
        .count_o (tag_count)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_pkt_t))
    ) u_inst_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (rsp_push),
        .data_i  (rsp_pkt),
        .pop_i   (id_pop),
        .head_o  (buf_head),
        .count_o (buf_count)
    );

    // On redirect every request still in flight after this cycle, including
    // one granted right now, belongs to the abandoned path and is discarded.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + {1'b0, grant} - {1'b0, rsp_valid};
        discard_d     = discard_q;

        if (grant) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (redirect_i) begin
            fetch_pc_d = word_align(redirect_pc_i);
            discard_d  = outstanding_d;
        end else if (rsp_valid && discard_q != 2'd0) begin
            discard_d  = discard_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q    <= word_align(RESET_PC);
            outstanding_q <= 2'd0;
            discard_q     <= 2'd0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    assign id_valid_o = (buf_count != 2'd0);
    assign id_pc_o    = id_valid_o ? buf_head.pc   : '0;
    assign id_inst_o  = id_valid_o ? buf_head.inst : NOP_INST;

    property p_rsp_has_request;
        @(posedge clk_i) disable iff (rst_i)
            imem_rvalid_i |-> (outstanding_q != 2'd0);
    endproperty
    a_rsp_has_request: assert property (p_rsp_has_request);

endmodule
